// File: rtl/tag_compare_pipe.sv
// Single-entry tag compare stage: pairs a request with its tag-read response and steers it
// to one of four class outputs (rh/rm/wh/wm). Optional counters enabled by TAG_CMP_STATS_EN.
module tag_compare_pipe #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned PAY_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [PAY_W-1:0]        req_pay,
  input  logic                    rtag_valid,
  output logic                    rtag_ready,
  input  logic [TAG_W-1:0]        rtag_i,
  input  logic                    rline_v,
  input  logic                    rline_d,
  input  logic [1:0]              rresp_i,
  output logic [ADDR_W+PAY_W:0]   out_pkt,
  output logic                    out_victim_dirty,
  output logic                    out_err,
  output logic                    rh_valid,
  output logic                    rm_valid,
  output logic                    wh_valid,
  output logic                    wm_valid,
  input  logic                    rh_ready,
  input  logic                    rm_ready,
  input  logic                    wh_ready,
  input  logic                    wm_ready,
  output logic [31:0]             stat_rh,
  output logic [31:0]             stat_rm,
  output logic [31:0]             stat_wh,
  output logic [31:0]             stat_wm
);

  typedef enum logic [1:0] {StIdle, StCmp, StOut} state_e;
  typedef enum logic [1:0] {ClsRh, ClsRm, ClsWh, ClsWm} cls_e;

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [PAY_W-1:0]    pay_q;
  logic [TAG_W-1:0]    rtag_q;
  logic                rline_v_q, rline_d_q;
  logic [1:0]          rresp_q;
  logic                err_q, vd_q;
  logic                accept, hit, cls_ready, in_out;
  logic [TAG_W-1:0]    tag_field;

  // Request and tag response are only ever taken together; reset masks the readies.
  assign accept     = rst_n & (state_q == StIdle) & req_valid & rtag_valid;
  assign req_ready  = accept;
  assign rtag_ready = accept;

  assign tag_field = addr_q[ADDR_W-1 -: TAG_W];
  assign hit       = rline_v_q & (tag_field == rtag_q) & (rresp_q == 2'b00);
  assign cls_d     = cls_e'({we_q, ~hit});

  always_comb begin
    cls_ready = 1'b0;
    unique case (cls_q)
      ClsRh:   cls_ready = rh_ready;
      ClsRm:   cls_ready = rm_ready;
      ClsWh:   cls_ready = wh_ready;
      ClsWm:   cls_ready = wm_ready;
      default: cls_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCmp;
      StCmp:   state_d = StOut;
      StOut:   if (cls_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cls_q     <= ClsRh;
      we_q      <= 1'b0;
      addr_q    <= '0;
      pay_q     <= '0;
      rtag_q    <= '0;
      rline_v_q <= 1'b0;
      rline_d_q <= 1'b0;
      rresp_q   <= 2'b00;
      err_q     <= 1'b0;
      vd_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= req_we;
        addr_q    <= req_addr;
        pay_q     <= req_pay;
        rtag_q    <= rtag_i;
        rline_v_q <= rline_v;
        rline_d_q <= rline_d;
        rresp_q   <= rresp_i;
      end
      if (state_q == StCmp) begin
        cls_q <= cls_d;
        err_q <= (rresp_q != 2'b00);
        vd_q  <= ~hit & rline_v_q & rline_d_q;
      end
    end
  end

  assign in_out           = (state_q == StOut);
  assign rh_valid         = in_out & (cls_q == ClsRh);
  assign rm_valid         = in_out & (cls_q == ClsRm);
  assign wh_valid         = in_out & (cls_q == ClsWh);
  assign wm_valid         = in_out & (cls_q == ClsWm);
  assign out_pkt          = {we_q, addr_q, pay_q};
  // Flags only carry meaning while a class valid is up.
  assign out_err          = in_out & err_q;
  assign out_victim_dirty = in_out & vd_q;

`ifdef TAG_CMP_STATS_EN
  logic [3:0]  fire;
  logic [31:0] cnt_q [4];

  assign fire = {wm_valid & wm_ready, wh_valid & wh_ready, rm_valid & rm_ready,
                 rh_valid & rh_ready};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && (cnt_q[i] != 32'hFFFF_FFFF)) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  assign stat_rh = cnt_q[0];
  assign stat_rm = cnt_q[1];
  assign stat_wh = cnt_q[2];
  assign stat_wm = cnt_q[3];
`else
  assign stat_rh = '0;
  assign stat_rm = '0;
  assign stat_wh = '0;
  assign stat_wm = '0;
`endif

endmodule

// File: tb/tb_tag_compare_pipe.sv
// Directed bench for tag_compare_pipe with a transaction-level reference model.
// Honours TAG_CMP_STATS_EN for the expected counter values.
module tb_tag_compare_pipe;

`ifdef TAG_CMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rtag_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic [15:0] req_pay = '0;
  logic [7:0]  rtag = '0;
  logic        rline_v = 1'b0, rline_d = 1'b0;
  logic [1:0]  rresp = '0;
  logic [3:0]  rdy = '0;
  logic        req_ready, rtag_ready, out_victim_dirty, out_err;
  logic        rh_valid, rm_valid, wh_valid, wm_valid;
  logic [80:0] out_pkt;
  logic [31:0] stat_rh, stat_rm, stat_wh, stat_wm;
  logic [3:0]  vv;

  int vectors = 0;
  int miscompares = 0;
  int txn_n = 0;

  always #5 clk = ~clk;

  tag_compare_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_pay(req_pay),
    .rtag_valid(rtag_valid), .rtag_ready(rtag_ready), .rtag_i(rtag),
    .rline_v(rline_v), .rline_d(rline_d), .rresp_i(rresp),
    .out_pkt(out_pkt), .out_victim_dirty(out_victim_dirty), .out_err(out_err),
    .rh_valid(rh_valid), .rm_valid(rm_valid), .wh_valid(wh_valid), .wm_valid(wm_valid),
    .rh_ready(rdy[0]), .rm_ready(rdy[1]), .wh_ready(rdy[2]), .wm_ready(rdy[3]),
    .stat_rh(stat_rh), .stat_rm(stat_rm), .stat_wh(stat_wh), .stat_wm(stat_wm)
  );

  assign vv = {wm_valid, wh_valid, rm_valid, rh_valid};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record, aged in cycles since acceptance.
  logic        m_busy = 1'b0;
  int          m_age = 0;
  logic [1:0]  m_cls = '0;
  logic        m_err = 1'b0, m_vd = 1'b0;
  logic [80:0] m_pkt = '0;
  logic [31:0] m_st [4] = '{default: 32'd0};

  function automatic logic m_hit(input logic [63:0] a, input logic [7:0] t, input logic v,
                                 input logic [1:0] r);
    return v && (a[63:56] == t) && (r == 2'b00);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_pkt  <= '0;
      for (int i = 0; i < 4; i++) m_st[i] <= 32'd0;
    end else if (!m_busy) begin
      if (req_valid && rtag_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_pkt  <= {req_we, req_addr, req_pay};
        m_cls  <= {req_we, !m_hit(req_addr, rtag, rline_v, rresp)};
        m_err  <= (rresp != 2'b00);
        m_vd   <= !m_hit(req_addr, rtag, rline_v, rresp) && rline_v && rline_d;
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (rdy[m_cls]) begin
      m_busy <= 1'b0;
      if (m_st[m_cls] != 32'hFFFF_FFFF) m_st[m_cls] <= m_st[m_cls] + 32'd1;
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    logic exp_rdy, shown;
    exp_rdy = rst_n && !m_busy && req_valid && rtag_valid;
    shown   = m_busy && (m_age >= 1);
    chk("req_ready", req_ready, exp_rdy);
    chk("rtag_ready", rtag_ready, exp_rdy);
    chk("class_valid", vv, shown ? (4'b0001 << m_cls) : 4'b0000);
    chk("out_pkt", out_pkt, m_pkt);
    chk("out_err", out_err, shown && m_err);
    chk("out_victim_dirty", out_victim_dirty, shown && m_vd);
    chk("stat_rh", stat_rh, STATS ? m_st[0] : 32'd0);
    chk("stat_rm", stat_rm, STATS ? m_st[1] : 32'd0);
    chk("stat_wh", stat_wh, STATS ? m_st[2] : 32'd0);
    chk("stat_wm", stat_wm, STATS ? m_st[3] : 32'd0);
  end

  // Called at negedge+1; returns at negedge+1 with the DUT idle again.
  task automatic send(input logic we, input logic [7:0] tag, input logic [7:0] rt,
                      input logic v, input logic d, input logic [1:0] resp, input int hold,
                      input int ecls, input logic eerr, input logic evd);
    int n;
    logic [63:0] a;
    logic [15:0] p;
    txn_n++;
    a = {tag, 56'h00_1234_5678_9A00} + 64'(txn_n);
    p = 16'(txn_n * 16'h0101);
    req_we = we; req_addr = a; req_pay = p;
    rtag = rt; rline_v = v; rline_d = d; rresp = resp;
    req_valid = 1'b1; rtag_valid = 1'b1;
    rdy = (hold > 0) ? 4'h0 : 4'hF;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", req_ready, 1'b1);
    if (!req_ready) begin
      req_valid = 1'b0; rtag_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk); #1;
    if (hold == 0) begin
      req_valid = 1'b0; rtag_valid = 1'b0;
    end
    chk("cmp_cycle_no_valid", vv, 4'b0000);
    @(negedge clk); #1;
    chk("lit_class", vv, 4'b0001 << ecls);
    chk("lit_err", out_err, eerr);
    chk("lit_victim", out_victim_dirty, evd);
    chk("lit_pkt", out_pkt, {we, a, p});
    for (int i = 0; i < hold; i++) begin
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_valid", vv, 4'b0001 << ecls);
      chk("hold_pkt", out_pkt, {we, a, p});
      @(negedge clk); #1;
    end
    req_valid = 1'b0; rtag_valid = 1'b0; rdy = 4'hF;
    n = 0;
    while (vv != 4'b0000 && n < 5) begin
      @(negedge clk); #1; n++;
    end
    chk("valid_drop", vv, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    req_valid = 1'b1; rtag_valid = 1'b1;
    #1;
    chk("reset_ready", req_ready, 1'b0);
    chk("reset_valid", vv, 4'b0000);
    chk("reset_pkt", out_pkt, 81'd0);
    rst_n = 1'b1;
    #1;
    chk("first_edge_ready", req_ready, 1'b1);

    // we, tag, rtag, v, d, resp, hold, class, err, victim
    send(1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
    send(1'b1, 8'h12, 8'h34, 1'b1, 1'b1, 2'b00, 0, 3, 1'b0, 1'b1);
    send(1'b0, 8'h5A, 8'h5A, 1'b1, 1'b1, 2'b10, 0, 1, 1'b1, 1'b1);
    send(1'b1, 8'h77, 8'h77, 1'b1, 1'b1, 2'b00, 10, 2, 1'b0, 1'b0);
    send(1'b0, 8'h3C, 8'h3C, 1'b0, 1'b1, 2'b00, 0, 1, 1'b0, 1'b0);
    send(1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 2'b00, 0, 3, 1'b0, 1'b0);
    send(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    send(1'b1, 8'h80, 8'h00, 1'b1, 1'b1, 2'b00, 0, 3, 1'b0, 1'b1);
    send(1'b1, 8'hC3, 8'hC3, 1'b1, 1'b0, 2'b01, 2, 3, 1'b1, 1'b0);

    // Request without a tag response is never accepted.
    req_valid = 1'b1; rtag_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lonely_req_ready", req_ready, 1'b0);
      chk("lonely_rtag_ready", rtag_ready, 1'b0);
      @(negedge clk); #1;
    end
    req_valid = 1'b0;

    // Reset while a class valid is being held off.
    req_we = 1'b0; req_addr = {8'h66, 56'h1}; req_pay = 16'hBEEF;
    rtag = 8'h66; rline_v = 1'b1; rline_d = 1'b0; rresp = 2'b00;
    rdy = 4'h0; req_valid = 1'b1; rtag_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    req_valid = 1'b0; rtag_valid = 1'b0;
    @(negedge clk); #1;
    chk("pre_reset_valid", vv, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", vv, 4'b0000);
    chk("async_reset_pkt", out_pkt, 81'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    rdy = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_reset_no_valid", vv, 4'b0000);
    end

    // Counter run: three read hits and two write misses.
    send(1'b0, 8'h10, 8'h10, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
    send(1'b1, 8'h20, 8'h21, 1'b1, 1'b1, 2'b00, 0, 3, 1'b0, 1'b1);
    send(1'b0, 8'h30, 8'h30, 1'b1, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0);
    send(1'b1, 8'h40, 8'h41, 1'b0, 1'b0, 2'b00, 1, 3, 1'b0, 1'b0);
    send(1'b0, 8'h50, 8'h50, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("lit_stat_rh", stat_rh, STATS ? 32'd3 : 32'd0);
    chk("lit_stat_rm", stat_rm, 32'd0);
    chk("lit_stat_wh", stat_wh, 32'd0);
    chk("lit_stat_wm", stat_wm, STATS ? 32'd2 : 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
